// File: rtl/udp_stream_framer.sv
`default_nettype none
// ============================================================================
// Module   : udp_stream_framer
// Purpose  : Buffers a non-stallable 32-bit sample stream in a show-ahead FIFO
//            and, once a full UDP payload is buffered and the packet sender is
//            idle, issues a one-cycle sync pulse followed by exactly one
//            payload of words over a valid/ready interface.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            i_enable            - accept source words and arm packets
//            i_src_data/i_src_vld- sample stream (cannot be stalled)
//            i_pkt_len           - payload length in bytes (word granularity)
//            i_ps_ready          - packet sender idle
//            o_sync              - one-cycle start pulse to packet sender
//            o_out_data/o_out_vld/i_out_rdy - payload word handshake
//            o_level             - FIFO occupancy in words
//            o_drop_cnt          - words dropped on full (saturating)
//            o_pkt_cnt           - packets completed (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module udp_stream_framer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [31:0]       i_src_data,
    input  logic              i_src_vld,
    input  logic [15:0]       i_pkt_len,
    input  logic              i_ps_ready,
    output logic              o_sync,
    output logic [31:0]       o_out_data,
    output logic              o_out_vld,
    input  logic              i_out_rdy,
    output logic [ADDR_W:0]   o_level,
    output logic [15:0]       o_drop_cnt,
    output logic [15:0]       o_pkt_cnt
);

    localparam int          c_DEPTH   = 1 << ADDR_W;
    localparam logic [31:0] c_DEPTH32 = 32'(c_DEPTH);
    localparam logic [ADDR_W:0] c_FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [31:0]       r_mem [c_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [15:0]       r_drop_cnt;

    logic w_full;
    logic w_wr;
    logic w_drop;
    logic w_rd;

    // Full is judged on the registered level only, so a read in the same
    // cycle never frees room for a write.
    assign w_full = (r_level == c_FULL);
    assign w_wr   = i_src_vld & i_enable & ~w_full;
    assign w_drop = i_src_vld & i_enable &  w_full;
    assign w_rd   = o_out_vld & i_out_rdy;

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_src_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_level <= r_level + 1'b1;
            end else if (!w_wr && w_rd) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet framing FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [13:0] r_pkt_words;
    logic [13:0] r_remaining;
    logic        r_busy_seen;
    logic [15:0] r_pkt_cnt;

    logic [13:0] w_len_words;
    logic [31:0] w_len32;
    logic [31:0] w_lvl32;
    logic        w_arm;
    logic        w_unused_len;

    assign w_len_words  = i_pkt_len[15:2];
    assign w_unused_len = ^i_pkt_len[1:0];
    assign w_len32      = {18'd0, w_len_words};
    assign w_lvl32      = 32'(r_level);

    // Lengths of zero or larger than the FIFO can never be satisfied and
    // therefore never arm.
    assign w_arm = i_enable & i_ps_ready
                 & (w_len32 != 32'd0)
                 & (w_len32 <= c_DEPTH32)
                 & (w_lvl32 >= w_len32);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pkt_words <= '0;
            r_remaining <= '0;
            r_busy_seen <= 1'b0;
            r_pkt_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arm) begin
                        r_pkt_words <= w_len_words;
                        r_state     <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    r_remaining <= r_pkt_words;
                    r_busy_seen <= 1'b0;
                    r_state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (!i_ps_ready) begin
                        r_busy_seen <= 1'b1;
                    end
                    if (w_rd) begin
                        r_remaining <= r_remaining - 14'd1;
                        if (r_remaining == 14'd1) begin
                            r_pkt_cnt <= r_pkt_cnt + 16'd1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Wait for the sender to have gone busy and come back,
                    // proving it consumed the previous sync.
                    if (!i_ps_ready) begin
                        r_busy_seen <= 1'b1;
                    end
                    if (r_busy_seen && i_ps_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign o_sync     = (r_state == S_SYNC);
    assign o_out_vld  = (r_state == S_STREAM) && (r_remaining != 14'd0);
    assign o_out_data = r_mem[r_rd_ptr];
    assign o_level    = r_level;
    assign o_drop_cnt = r_drop_cnt;
    assign o_pkt_cnt  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_udp_stream_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_stream_framer
// Purpose  : Directed self-checking bench for udp_stream_framer. Instance A
//            uses the default 1024-word FIFO; instance B uses a 4-word FIFO
//            for the full/drop boundary cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_stream_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_en, a_svld, a_psr, a_rdy, a_sync, a_vld;
    logic [31:0] a_src, a_dout;
    logic [15:0] a_len, a_drop, a_pkt;
    logic [10:0] a_level;

    logic        b_en, b_svld, b_psr, b_rdy, b_sync, b_vld;
    logic [31:0] b_src, b_dout;
    logic [15:0] b_len, b_drop, b_pkt;
    logic [2:0]  b_level;

    udp_stream_framer #(.ADDR_W(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_enable(a_en), .i_src_data(a_src),
        .i_src_vld(a_svld), .i_pkt_len(a_len), .i_ps_ready(a_psr),
        .o_sync(a_sync), .o_out_data(a_dout), .o_out_vld(a_vld),
        .i_out_rdy(a_rdy), .o_level(a_level), .o_drop_cnt(a_drop),
        .o_pkt_cnt(a_pkt)
    );

    udp_stream_framer #(.ADDR_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_enable(b_en), .i_src_data(b_src),
        .i_src_vld(b_svld), .i_pkt_len(b_len), .i_ps_ready(b_psr),
        .o_sync(b_sync), .o_out_data(b_dout), .o_out_vld(b_vld),
        .i_out_rdy(b_rdy), .o_level(b_level), .o_drop_cnt(b_drop),
        .o_pkt_cnt(b_pkt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer / sync monitor for instance A, plus hold-stability check.
    int          cyc = 0;
    logic [31:0] q_a[$];
    int          q_cyc[$];
    int          sync_a = 0;
    int          sync_b = 0;
    int          sync_cyc_a = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_stall) begin
            check("hold_vld", 32'(a_vld), 32'd1);
            check("hold_data", a_dout, prev_data);
        end
        prev_stall = a_vld & ~a_rdy;
        prev_data  = a_dout;
        if (a_vld & a_rdy) begin
            q_a.push_back(a_dout);
            q_cyc.push_back(cyc);
        end
        if (a_sync) begin
            sync_a++;
            sync_cyc_a = cyc;
        end
        if (b_sync) sync_b++;
    end

    task automatic write_a(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            a_src  = 32'(first + i);
            a_svld = 1'b1;
            tick();
        end
        a_svld = 1'b0;
    endtask

    task automatic write_b(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            b_src  = 32'(first + i);
            b_svld = 1'b1;
            tick();
        end
        b_svld = 1'b0;
    endtask

    task automatic wait_pkt_a(input logic [15:0] target);
        for (int k = 0; k < 100; k++) begin
            if (a_pkt == target) break;
            tick();
        end
        check("pkt_cnt", 32'(a_pkt), 32'(target));
    endtask

    task automatic wait_sync_a();
        for (int k = 0; k < 100; k++) begin
            if (a_sync) break;
            tick();
        end
        check("sync_seen", 32'(a_sync), 32'd1);
    endtask

    // Sender goes busy for one cycle and returns, letting DONE exit.
    task automatic release_done_a();
        a_psr = 1'b0;
        tick();
        a_psr = 1'b1;
        tick();
        tick();
    endtask

    task automatic check_q(input int base, input int n);
        check("xfer_count", 32'(q_a.size()), 32'(n));
        if (q_a.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check("xfer_word", q_a[i], 32'(base + i));
            end
        end
    endtask

    logic [3:0] rdy_pat;

    initial begin
        rst_n = 1'b0;
        a_en = 0; a_svld = 0; a_psr = 0; a_rdy = 0; a_src = '0; a_len = '0;
        b_en = 0; b_svld = 0; b_psr = 0; b_rdy = 0; b_src = '0; b_len = '0;
        rdy_pat = 4'b1001;
        tick();
        tick();

        // Reset state
        check("rst_sync", 32'(a_sync), 32'd0);
        check("rst_vld", 32'(a_vld), 32'd0);
        check("rst_level", 32'(a_level), 32'd0);
        check("rst_drop", 32'(a_drop), 32'd0);
        check("rst_pkt", 32'(a_pkt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Small FIFO: invalid length, overflow drops, enable gating,
        // then a write colliding with a read at full.
        b_en = 1; b_len = 16'd0; b_psr = 1; b_rdy = 1;
        write_b(1, 7);
        tick();
        check("b_level_full", 32'(b_level), 32'd4);
        check("b_drop3", 32'(b_drop), 32'd3);
        check("b_no_sync", 32'(sync_b), 32'd0);
        b_en = 0; b_svld = 1; b_src = 32'hBEEF;
        tick();
        b_svld = 0; b_en = 1;
        check("b_dis_drop", 32'(b_drop), 32'd3);
        b_len = 16'd16;
        for (int k = 0; k < 20; k++) begin
            if (b_sync) break;
            tick();
        end
        check("b_sync", 32'(b_sync), 32'd1);
        tick();
        check("b_stream_vld", 32'(b_vld), 32'd1);
        b_src = 32'hDEAD; b_svld = 1;
        tick();
        b_svld = 0;
        check("b_drop_rd", 32'(b_drop), 32'd4);
        check("b_level_rd", 32'(b_level), 32'd3);
        for (int k = 0; k < 20; k++) begin
            if (b_pkt == 16'd1) break;
            tick();
        end
        check("b_pkt", 32'(b_pkt), 32'd1);
        check("b_level_end", 32'(b_level), 32'd0);

        // Basic 4-word packet
        a_en = 1; a_len = 16'd16; a_psr = 1; a_rdy = 1;
        q_a.delete(); q_cyc.delete(); sync_a = 0;
        write_a(1, 4);
        wait_pkt_a(16'd1);
        check_q(1, 4);
        check("t1_sync_cnt", 32'(sync_a), 32'd1);
        if (q_cyc.size() == 4) begin
            check("t1_first_lat", 32'(q_cyc[0]), 32'(sync_cyc_a + 1));
            check("t1_consec", 32'(q_cyc[3]), 32'(q_cyc[0] + 3));
        end
        check("t1_level", 32'(a_level), 32'd0);
        check("t1_vld_off", 32'(a_vld), 32'd0);
        release_done_a();

        // Backpressure 1,0,0,1
        q_a.delete(); sync_a = 0;
        write_a(5, 4);
        for (int k = 0; k < 60; k++) begin
            a_rdy = rdy_pat[k % 4];
            tick();
            if (a_pkt == 16'd2) break;
        end
        a_rdy = 1;
        check("t2_pkt", 32'(a_pkt), 32'd2);
        check_q(5, 4);
        check("t2_sync_cnt", 32'(sync_a), 32'd1);
        tick();
        check("t2_vld_off", 32'(a_vld), 32'd0);
        release_done_a();

        // Sender-ready gating and DONE handshake
        q_a.delete(); sync_a = 0;
        a_psr = 0;
        write_a(9, 8);
        repeat (5) tick();
        check("t3_no_sync", 32'(sync_a), 32'd0);
        check("t3_level8", 32'(a_level), 32'd8);
        a_psr = 1;
        wait_sync_a();
        tick();
        tick();
        a_psr = 0;
        wait_pkt_a(16'd3);
        check_q(9, 4);
        repeat (5) tick();
        check("t3_no_rearm", 32'(sync_a), 32'd1);
        check("t3_level4", 32'(a_level), 32'd4);
        a_psr = 1;
        wait_pkt_a(16'd4);
        check("t3_sync2", 32'(sync_a), 32'd2);
        check_q(9, 8);
        release_done_a();

        // Length change during STREAM only affects the next packet
        q_a.delete(); sync_a = 0;
        a_len = 16'd16;
        write_a(17, 4);
        wait_sync_a();
        a_len = 16'd32;
        wait_pkt_a(16'd5);
        check_q(17, 4);
        release_done_a();
        write_a(21, 4);
        repeat (6) tick();
        check("t5_wait8", 32'(sync_a), 32'd1);
        check("t5_level4", 32'(a_level), 32'd4);
        write_a(25, 4);
        wait_pkt_a(16'd6);
        check_q(17, 12);
        release_done_a();
        a_len = 16'd16;

        // Reset mid-STREAM after two words
        q_a.delete();
        write_a(29, 4);
        wait_sync_a();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (q_a.size() >= 2) break;
        end
        rst_n = 1'b0;
        tick();
        check("t6_sync", 32'(a_sync), 32'd0);
        check("t6_vld", 32'(a_vld), 32'd0);
        check("t6_level", 32'(a_level), 32'd0);
        check("t6_pkt", 32'(a_pkt), 32'd0);
        check("t6_partial", 32'(q_a.size()), 32'd2);
        rst_n = 1'b1;
        tick();
        q_a.delete();
        write_a(33, 4);
        wait_pkt_a(16'd1);
        check_q(33, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/udp_stream_framer.md
Name: udp_stream_framer

Overview:
- Sits directly upstream of the packet sender, on the data-stream side.
- Buffers a non-stallable 32-bit sample stream in an internal FIFO.
- When a full UDP payload is available and the sender is idle, it issues a one-cycle sync pulse, then delivers exactly one payload of words through the sender's valid/ready data input.
- Counts dropped words and packets sent, for status readout.

Parameters:
- ADDR_W, 10, FIFO address width; depth = 2^ADDR_W words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  1 = accept source words and arm packets
- i_src_data  in  32  sample stream word
- i_src_vld  in  1  source word valid; source cannot be stalled
- i_pkt_len  in  16  UDP payload length in bytes; words = i_pkt_len[15:2], bits [1:0] ignored
- i_ps_ready  in  1  packet sender idle and able to take a sync
- o_sync  out  1  one-cycle start pulse to packet sender
- o_out_data  out  32  payload word to packet sender
- o_out_vld  out  1  payload word valid
- i_out_rdy  in  1  packet sender accepts word
- o_level  out  ADDR_W+1  FIFO occupancy in words
- o_drop_cnt  out  16  words dropped on full, saturating
- o_pkt_cnt  out  16  packets completed, wrapping

Behaviour:
- Reset, asynchronous and active-low, clears all state.
  - o_sync=0, o_out_vld=0, o_level=0, o_drop_cnt=0, o_pkt_cnt=0.
  - FIFO empty, FSM in IDLE; o_out_data is don't-care.
- Write side:
  - Write occurs when i_src_vld & i_enable & ~full.
  - full means o_level == 2^ADDR_W, using the registered level of the current cycle.
  - A write is dropped when full, even if a read occurs in the same cycle. o_drop_cnt then increments and saturates at 16'hFFFF.
  - When i_enable=0, writes are ignored and not counted as drops.
- Read side:
  - A read occurs on o_out_vld & i_out_rdy.
  - FIFO is show-ahead: o_out_data is valid together with o_out_vld.
  - o_level updates next cycle: +1 for write only, -1 for read only, unchanged when both occur.
- Latched length: on leaving IDLE, pkt_words = i_pkt_len[15:2] is latched. Later changes to i_pkt_len affect only the next packet.
- FSM states: IDLE, SYNC, STREAM, DONE.
  - IDLE → SYNC when all hold:
    - i_enable
    - i_ps_ready
    - pkt_words != 0
    - pkt_words <= 2^ADDR_W
    - o_level >= pkt_words
  - SYNC: o_sync=1 for exactly this one cycle; remaining ← pkt_words; busy_seen ← 0; next state STREAM.
  - STREAM:
    - o_out_vld = (remaining != 0). The FIFO is guaranteed non-empty here because only this FSM reads it.
    - Each transfer decrements remaining.
    - busy_seen is set whenever i_ps_ready=0.
    - On the transfer with remaining==1: o_pkt_cnt+1 (wrapping), then go to DONE.
  - DONE:
    - o_out_vld=0.
    - Stay until busy_seen=1 and i_ps_ready=1, then go to IDLE.
    - busy_seen keeps updating in DONE.
    - This prevents re-arming before the sender has registered the previous sync.
- Latency: the earliest o_sync is 1 cycle after the condition holds in IDLE; the first word can transfer 1 cycle after o_sync.
- Invalid length: pkt_words == 0 or > 2^ADDR_W never arms. The FIFO fills and then drops; there is no error flag.
- i_enable deasserted mid-packet: the current packet completes (the words are already buffered) and no new arm occurs.
- Reset mid-packet: returns immediately to the reset state. Buffered words are discarded, and the sender must also be reset.
- o_out_vld never deasserts within a packet before the last word.
- o_out_data is held stable while o_out_vld=1 and i_out_rdy=0.

Test Plan:
- ADDR_W=10, i_pkt_len=16 (4 words), write 4 words 0x1..0x4, i_ps_ready=1, i_out_rdy=1 → o_sync pulses once for 1 cycle; words 0x1,0x2,0x3,0x4 transfer in order on 4 consecutive cycles; o_pkt_cnt=1; o_level=0.
- Same setup with i_out_rdy toggled 1,0,0,1 each cycle → o_out_data held stable during stalls; exactly 4 transfers; no extra o_vld.
- Hold i_ps_ready=0 with 8 words buffered → no o_sync. Raise i_ps_ready → o_sync pulses. Drop i_ps_ready 2 cycles after sync and raise it after the last word → a second packet arms only after that rise.
- ADDR_W=2 (depth 4), i_pkt_len=0, write 7 words → o_level=4, o_drop_cnt=3, no o_sync. Write with simultaneous read at full → write dropped.
- Change i_pkt_len from 16 to 32 during STREAM → current packet stays 4 words; next packet waits for 8 words.
- Assert rst_n=0 mid-STREAM after 2 of 4 words → all outputs 0 next cycle, o_level=0; after release, a fresh 4-word packet is framed correctly.
